// File: rtl/sysbus_mem_responder.sv
// ----------------------------------------------------------------------------
// sysbus_mem_responder
//
// Memory-side responder on the 16-bit system bus. The datapath latches an
// address with Ale, then requests a data phase with MemEn/RnW. The block
// holds Stall for WAIT_STATES cycles, then completes the transfer in a
// single XFER cycle: a read drives SysBus_Out with SysBus_OE, a write
// commits SysBus_In into the local word-addressed RAM. Done pulses for the
// XFER cycle.
//
// Optional feature macro: SYSBUS_BUSERR_EN
//   Defined   : an address >= DEPTH flags BusErr in the XFER cycle, reads
//               return zero and writes are dropped.
//   Undefined : BusErr is tied low and high addresses alias onto the low
//               AW bits.
//
// Parameters:
//   DATA_W      bus and memory word width
//   DEPTH       number of memory words (power of two, 2..2^DATA_W)
//   WAIT_STATES wait cycles inserted per access (0..15)
//
// Ports:
//   Clock       system clock, rising edge
//   Reset       asynchronous active-high reset
//   Ale         address latch enable, SysBus_In carries the address
//   MemEn       data-phase request, honoured only after an address phase
//   RnW         1 = read, 0 = write; sampled with MemEn
//   SysBus_In   address or write data from the datapath
//   SysBus_Out  registered read data
//   SysBus_OE   SysBus_Out is valid and driving the bus
//   Stall       wait request to the control unit
//   Done        one-cycle transfer-complete pulse
//   BusErr      out-of-range access flag (feature build only)
// ----------------------------------------------------------------------------
module sysbus_mem_responder #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Ale,
    input  logic              MemEn,
    input  logic              RnW,
    input  logic [DATA_W-1:0] SysBus_In,
    output logic [DATA_W-1:0] SysBus_Out,
    output logic              SysBus_OE,
    output logic              Stall,
    output logic              Done,
    output logic              BusErr
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWait,
        StXfer
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] addr_q;
    logic [3:0]        cnt_q;
    logic              rd_q;
    logic [DATA_W-1:0] out_q;
    logic              oe_q;
    logic              stall_q;
    logic              done_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     idx;
    logic              addr_oor;
    logic [DATA_W-1:0] rd_word;

    assign idx = addr_q[AW-1:0];

    // Address cannot change between the MemEn sample and the end of XFER
    // (Ale is ignored in WAIT and XFER), so the range check can be taken
    // straight from addr_q instead of being latched separately.
`ifdef SYSBUS_BUSERR_EN
    assign addr_oor = (addr_q >> AW) != '0;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^(addr_q >> AW);
    assign addr_oor       = 1'b0;
`endif

    assign rd_word = addr_oor ? '0 : mem[idx];

    // Control FSM; every output is a register updated here.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            out_q   <= '0;
            oe_q    <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // MemEn without a preceding Ale is deliberately ignored.
                    if (Ale) begin
                        addr_q  <= SysBus_In;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (MemEn) begin
                        // MemEn wins over a simultaneous Ale.
                        rd_q  <= RnW;
                        cnt_q <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state_q <= StXfer;
                            done_q  <= 1'b1;
                            err_q   <= addr_oor;
                            if (RnW) begin
                                oe_q  <= 1'b1;
                                out_q <= rd_word;
                            end
                        end else begin
                            state_q <= StWait;
                            stall_q <= 1'b1;
                        end
                    end else if (Ale) begin
                        addr_q <= SysBus_In;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        stall_q <= 1'b0;
                        state_q <= StXfer;
                        done_q  <= 1'b1;
                        err_q   <= addr_oor;
                        if (rd_q) begin
                            oe_q  <= 1'b1;
                            out_q <= rd_word;
                        end
                    end
                end
                StXfer: begin
                    oe_q    <= 1'b0;
                    out_q   <= '0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // RAM is not reset. A write commits on the edge that ends XFER; an
    // asynchronous reset before that edge forces StIdle and drops it.
    always_ff @(posedge Clock) begin
        if (state_q == StXfer && !rd_q && !addr_oor) begin
            mem[idx] <= SysBus_In;
        end
    end

    assign SysBus_Out = out_q;
    assign SysBus_OE  = oe_q;
    assign Stall      = stall_q;
    assign Done       = done_q;
    assign BusErr     = err_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
module tb_sysbus_mem_responder;

    logic        clk;
    logic        rst;
    logic        ale;
    logic        mem_en;
    logic        rnw;
    logic [15:0] bus_in;

    // WAIT_STATES = 1 instance
    logic [15:0] bus_out;
    logic        oe, stall, done, buserr;
    // WAIT_STATES = 0 instance, shares all inputs
    logic [15:0] bus_out_z;
    logic        oe_z, stall_z, done_z, buserr_z;

    int tests = 0;
    int fails = 0;

    sysbus_mem_responder #(
        .DATA_W      (16),
        .DEPTH       (256),
        .WAIT_STATES (1)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Ale        (ale),
        .MemEn      (mem_en),
        .RnW        (rnw),
        .SysBus_In  (bus_in),
        .SysBus_Out (bus_out),
        .SysBus_OE  (oe),
        .Stall      (stall),
        .Done       (done),
        .BusErr     (buserr)
    );

    sysbus_mem_responder #(
        .DATA_W      (16),
        .DEPTH       (256),
        .WAIT_STATES (0)
    ) dut_z (
        .Clock      (clk),
        .Reset      (rst),
        .Ale        (ale),
        .MemEn      (mem_en),
        .RnW        (rnw),
        .SysBus_In  (bus_in),
        .SysBus_Out (bus_out_z),
        .SysBus_OE  (oe_z),
        .Stall      (stall_z),
        .Done       (done_z),
        .BusErr     (buserr_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge; return 1 ns after it so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ale(input logic [15:0] a);
        ale    = 1'b1;
        bus_in = a;
        tick();
        ale    = 1'b0;
    endtask

    // Returns just after the MemEn sample edge; bus_in stays as write data.
    task automatic drive_mem(input logic r, input logic [15:0] d);
        mem_en = 1'b1;
        rnw    = r;
        bus_in = d;
        tick();
        mem_en = 1'b0;
    endtask

    // Full write through both instances; ends with both back in IDLE.
    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        drive_ale(a);
        drive_mem(1'b0, d);
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests++; if (bus_out !== 16'h0) begin fails++; $display("FAIL rst_out: got %h want 0000", bus_out); end
        tests++; if ({oe, stall, done, buserr} !== 4'b0) begin fails++; $display("FAIL rst_flags: got %b want 0000", {oe, stall, done, buserr}); end
        tests++; if ({oe_z, stall_z, done_z, buserr_z} !== 4'b0) begin fails++; $display("FAIL rst_flags_z: got %b want 0000", {oe_z, stall_z, done_z, buserr_z}); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        drive_ale(16'h0012);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL wr_stall_addr: got %b want 0", stall); end
        drive_mem(1'b0, 16'hBEEF);
        tests++; if ({stall, done, oe} !== 3'b100) begin fails++; $display("FAIL wr_wait: got %b want 100", {stall, done, oe}); end
        tick();
        tests++; if ({stall, done, oe, buserr} !== 4'b0100) begin fails++; $display("FAIL wr_xfer: got %b want 0100", {stall, done, oe, buserr}); end
        tick();
        tests++; if ({stall, done, oe} !== 3'b000) begin fails++; $display("FAIL wr_end: got %b want 000", {stall, done, oe}); end
        drive_ale(16'h0012);
        drive_mem(1'b1, 16'h0000);
        tests++; if ({stall, oe, done} !== 3'b100) begin fails++; $display("FAIL rd_wait: got %b want 100", {stall, oe, done}); end
        tick();
        tests++; if ({stall, oe, done} !== 3'b011) begin fails++; $display("FAIL rd_xfer: got %b want 011", {stall, oe, done}); end
        tests++; if (bus_out !== 16'hBEEF) begin fails++; $display("FAIL rd_data: got %h want beef", bus_out); end
        tick();
        tests++; if ({oe, done} !== 2'b00) begin fails++; $display("FAIL rd_end: got %b want 00", {oe, done}); end
        tests++; if (bus_out !== 16'h0000) begin fails++; $display("FAIL rd_end_out: got %h want 0000", bus_out); end
    endtask

    task automatic test_relatch();
        write_word(16'h0005, 16'h1111);
        write_word(16'h0007, 16'h7777);
        drive_ale(16'h0005);
        drive_ale(16'h0007);
        drive_mem(1'b1, 16'h0000);
        tick();
        tests++; if (bus_out !== 16'h7777) begin fails++; $display("FAIL relatch_data: got %h want 7777", bus_out); end
        tick();
        // MemEn together with Ale: the Ale address must be ignored.
        drive_ale(16'h0005);
        ale = 1'b1;
        drive_mem(1'b1, 16'h0007);
        ale = 1'b0;
        tick();
        tests++; if (bus_out !== 16'h1111) begin fails++; $display("FAIL memen_prio: got %h want 1111", bus_out); end
        tick();
    endtask

    task automatic test_idle_memen();
        drive_mem(1'b1, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({done, oe, stall, done_z, oe_z} !== 5'b0) begin
                fails++;
                $display("FAIL idle_memen[%0d]: got %b want 00000", i, {done, oe, stall, done_z, oe_z});
            end
            tick();
        end
    endtask

    task automatic test_zero_wait();
        write_word(16'h0020, 16'hCAFE);
        drive_ale(16'h0020);
        drive_mem(1'b1, 16'h0000);
        tests++; if ({oe_z, done_z, stall_z} !== 3'b110) begin fails++; $display("FAIL zw_xfer: got %b want 110", {oe_z, done_z, stall_z}); end
        tests++; if (bus_out_z !== 16'hCAFE) begin fails++; $display("FAIL zw_data: got %h want cafe", bus_out_z); end
        tick();
        tests++; if ({oe_z, done_z, stall_z} !== 3'b000) begin fails++; $display("FAIL zw_end: got %b want 000", {oe_z, done_z, stall_z}); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        write_word(16'h0030, 16'h3030);
        drive_ale(16'h0030);
        drive_mem(1'b0, 16'h9999);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL mid_stall: got %b want 1", stall); end
        rst = 1'b1;
        #1;
        tests++; if ({stall, done, oe, bus_out} !== 19'b0) begin fails++; $display("FAIL mid_rst: got %b want 0", {stall, done, oe, bus_out}); end
        tick();
        rst = 1'b0;
        drive_ale(16'h0030);
        drive_mem(1'b1, 16'h0000);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL post_rst_stall: got %b want 1", stall); end
        tick();
        tests++; if (bus_out !== 16'h3030) begin fails++; $display("FAIL write_dropped: got %h want 3030", bus_out); end
        tick();
    endtask

`ifndef SYSBUS_BUSERR_EN
    task automatic test_alias();
        write_word(16'h0105, 16'h1234);
        drive_ale(16'h0005);
        drive_mem(1'b1, 16'h0000);
        tick();
        tests++; if (bus_out !== 16'h1234) begin fails++; $display("FAIL alias_data: got %h want 1234", bus_out); end
        tests++; if (buserr !== 1'b0) begin fails++; $display("FAIL alias_buserr: got %b want 0", buserr); end
        tick();
    endtask
`else
    task automatic test_buserr();
        write_word(16'h0000, 16'h5A5A);
        drive_ale(16'h0300);
        drive_mem(1'b0, 16'hAAAA);
        tick();
        tests++; if ({buserr, done} !== 2'b11) begin fails++; $display("FAIL be_wr: got %b want 11", {buserr, done}); end
        tick();
        tests++; if (buserr !== 1'b0) begin fails++; $display("FAIL be_wr_end: got %b want 0", buserr); end
        drive_ale(16'h0000);
        drive_mem(1'b1, 16'h0000);
        tick();
        tests++; if (bus_out !== 16'h5A5A) begin fails++; $display("FAIL be_ram_kept: got %h want 5a5a", bus_out); end
        tick();
        drive_ale(16'h0300);
        drive_mem(1'b1, 16'h0000);
        tick();
        tests++; if ({buserr, oe, done} !== 3'b111) begin fails++; $display("FAIL be_rd_flags: got %b want 111", {buserr, oe, done}); end
        tests++; if (bus_out !== 16'h0000) begin fails++; $display("FAIL be_rd_data: got %h want 0000", bus_out); end
        tick();
    endtask
`endif

    initial begin
        rst    = 1'b1;
        ale    = 1'b0;
        mem_en = 1'b0;
        rnw    = 1'b0;
        bus_in = 16'h0000;
        test_reset();
        test_write_read();
        test_relatch();
        test_idle_memen();
        test_zero_wait();
        test_reset_mid_wait();
`ifndef SYSBUS_BUSERR_EN
        test_alias();
`else
        test_buserr();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
